unary_matmul_engine: RTL
========================

// Module: unary_matmul_engine
// PURPOSE
//  Parametrised successor to the 2-bit unary systolic matmul: computes C = A x B for
//  A (M x K) and B (K x N) using unary-stream x binary-magnitude MAC cells.
//  Non-square shapes, signed/unsigned mode, valid/ready handshakes and optional
//  accumulate-into-C for tiled matmul. Sits between the tile loader and result writeback.
// PARAMETERS
//  BIT_WIDTH  4                    operand width (two's complement when SIGNED=1)
//  M          2                    rows of A / C
//  K          3                    inner dimension
//  N          2                    columns of B / C
//  SIGNED     1                    1: signed operands; 0: unsigned
//  ACC_WIDTH  2*BIT_WIDTH+$clog2(K) accumulator / C element width
// PORTS
//  clk        in   1                 single clock, rising edge
//  reset      in   1                 synchronous, active-high
//  in_valid   in   1                 A/B/acc_en valid
//  in_ready   out  1                 engine idle, can accept
//  acc_en     in   1                 1: add into current C; 0: clear C first
//  A          in   M*K*BIT_WIDTH     packed [M-1:0][K-1:0][BIT_WIDTH-1:0]
//  B          in   K*N*BIT_WIDTH     packed [K-1:0][N-1:0][BIT_WIDTH-1:0]
//  out_valid  out  1                 C holds a final result
//  out_ready  in   1                 consumer takes C
//  busy       out  1                 state != IDLE
//  C          out  M*N*ACC_WIDTH     packed [M-1:0][N-1:0][ACC_WIDTH-1:0]; signed if SIGNED
// BEHAVIOUR
//  - PHASE = SIGNED ? 2**(BIT_WIDTH-1) : 2**BIT_WIDTH-1. Magnitudes are BIT_WIDTH bits wide,
//    so -2**(BIT_WIDTH-1) has a full magnitude of 2**(BIT_WIDTH-1), with no truncation.
//  - FSM IDLE -> STREAM -> DONE -> IDLE. in_ready = (state==IDLE); busy = !in_ready.
//  - IDLE: on in_valid & in_ready, register A, B, and sign bits. If acc_en=0, clear all
//    accumulators; otherwise keep them. Set k=0, cnt=0 and go to STREAM.
//  - STREAM: on every edge, each cell (m,n) does acc += (cnt < |A[m][k]|) ? s*|B[k][n]| : 0.
//    s = -1 if sign(A[m][k]) xor sign(B[k][n]); otherwise s = +1. Sign is ignored when
//    SIGNED=0. cnt increments.
//  - At cnt==PHASE-1: cnt<=0 and k<=k+1. If k==K-1, go to DONE instead.
//  - Latency: out_valid rises exactly K*PHASE edges after the accepting edge
//    (24 at default parameters).
//  - DONE: out_valid=1; C and all state are held stable. On out_ready, go to IDLE.
//    out_valid drops on the next cycle; in_ready rises on that same cycle. There is no
//    accept in the same cycle as the output handshake.
//  - C is the accumulator array, driven directly. It is checked only while out_valid=1.
//    Accumulators hold their value in IDLE, which is what makes acc_en meaningful.
//  - in_valid is ignored outside IDLE. A/B need only be stable on the accepting edge.
//  - Arithmetic wraps modulo 2**ACC_WIDTH. With acc_en=0 the default ACC_WIDTH never
//    overflows. With acc_en=1, overflow is the caller's concern.
//  - Reset, including mid-STREAM or in DONE: next cycle state=IDLE, all accumulators 0,
//    k=cnt=0. Reset values: in_ready=1, out_valid=0, busy=0, C=0.
//  - reset has priority over all handshakes in the same cycle.
// TESTING (defaults unless noted)
//  1 A=[[1,2,3],[4,5,6]], B=[[1,2],[3,4],[5,6]], acc_en=0 -> out_valid exactly 24 cycles
//    after accept; C=[[22,28],[49,64]].
//  2 A all -8, B all -8 -> every C=192. Repeat with B all 7 -> every C=-168.
//  3 SIGNED=0: A all 15, B all 15 -> PHASE=15; out_valid after 45 cycles; every C=675.
//  4 Hold out_ready=0 for 10 cycles after out_valid, with in_valid pulsed meanwhile ->
//    C stable, out_valid held, in_ready=0, no new accept. out_ready=1 -> IDLE next cycle.
//  5 Run test 1, then repeat it with acc_en=1 -> C=[[44,56],[98,128]].
//  6 Assert reset 10 cycles into STREAM -> next cycle in_ready=1, out_valid=0, C=0.
//    A following test-1 transaction yields the correct result.

Source files
------------

// File: rtl/unary_matmul_engine.sv
// Unary-stream x binary-magnitude matrix multiply engine.
// Computes C = A x B (plus the previous C when acc_en=1) for A (M x K) and B (K x N).
// For each inner index k, every A element is streamed as a unary count over PHASE cycles.
// While the count is below |A[m][k]|, cell (m,n) adds the signed magnitude of B[k][n].
module unary_matmul_engine #(
    parameter int BIT_WIDTH = 4,
    parameter int M         = 2,
    parameter int K         = 3,
    parameter int N         = 2,
    parameter int SIGNED    = 1,
    parameter int ACC_WIDTH = 2*BIT_WIDTH + $clog2(K)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       acc_en,
    input  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]         A,
    input  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]         B,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic [M-1:0][N-1:0][ACC_WIDTH-1:0]         C
);

    // Unary stream length per inner index: the largest magnitude an operand can have.
    localparam int PHASE     = (SIGNED != 0) ? 2**(BIT_WIDTH-1) : 2**BIT_WIDTH - 1;
    localparam int KW        = (K > 1) ? $clog2(K) : 1;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam logic [BIT_WIDTH-1:0] CNT_LAST = BIT_WIDTH'(PHASE - 1);
    localparam logic [KW-1:0]        K_LAST   = KW'(K - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                                   state;
    logic [KW-1:0]                            k_idx;
    logic [BIT_WIDTH-1:0]                     cnt;
    logic [M-1:0][N-1:0][ACC_WIDTH-1:0]       acc;
    logic [M-1:0][N-1:0][ACC_WIDTH-1:0]       acc_next;
    logic [ACC_WIDTH-1:0]                     term;

    logic [M-1:0][K-1:0][BIT_WIDTH-1:0]       a_mag;
    logic [M-1:0][K-1:0]                      a_sgn;
    logic [K-1:0][N-1:0][BIT_WIDTH-1:0]       b_mag;
    logic [K-1:0][N-1:0]                      b_sgn;

    assign C    = acc;
    assign busy = !in_ready;

    // Operand capture: split A and B into sign bits and full-width magnitudes on accept.
    // NOTE: operand registers carry no reset; they are only read after a capture overwrites them.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && in_valid) begin
            for (int m = 0; m < M; m++) begin
                for (int k = 0; k < K; k++) begin
                    a_sgn[m][k] <= IS_SIGNED && A[m][k][BIT_WIDTH-1];
                    a_mag[m][k] <= (IS_SIGNED && A[m][k][BIT_WIDTH-1]) ? -A[m][k] : A[m][k];
                end
            end
            for (int k = 0; k < K; k++) begin
                for (int n = 0; n < N; n++) begin
                    b_sgn[k][n] <= IS_SIGNED && B[k][n][BIT_WIDTH-1];
                    b_mag[k][n] <= (IS_SIGNED && B[k][n][BIT_WIDTH-1]) ? -B[k][n] : B[k][n];
                end
            end
        end
    end

    // MAC array: each cell adds +/-|B[k][n]| while the unary count is below |A[m][k]|.
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        acc_next = acc;
        term     = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                term = {{(ACC_WIDTH-BIT_WIDTH){1'b0}}, b_mag[k_idx][n]};
                if (a_sgn[m][k_idx] ^ b_sgn[k_idx][n]) begin
                    term = -term;
                end
                if (cnt < a_mag[m][k_idx]) begin
                    acc_next[m][n] = acc[m][n] + term;
                end
            end
        end
    end

    // Control FSM: accept in IDLE, stream K*PHASE cycles, hold the result in DONE until taken.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            k_idx     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!acc_en) begin
                            acc <= '0;
                        end
                        k_idx    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    acc <= acc_next;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (k_idx == K_LAST) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            k_idx <= k_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
